sprite_line_fetcher: RTL and testbench

- Initiator side of the sprite ROM bank. The ROM bank takes a sprite number, a row and a column, and returns a 4-bit colour code one cycle later.
- During horizontal blanking, this block walks the sprite attribute table for the next scanline. For each visible sprite it requests the 32 pixels of the relevant row, then writes the non-transparent colour codes into the scanline buffer.
- Sits between the attribute RAM (CPU-written), the sprite ROM bank, and the line buffer read by the colour palette stage.

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_pixel_writer.sv | 41 ++++
 rtl/sprite_line_fetcher.sv | 140 ++++++++++++++
 tb/tb_sprite_line_fetcher.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line fetcher.
package sprite_pkg;

  localparam int unsigned SPR_SIZE = 32;
  localparam logic [3:0] TRANSPARENT = 4'h0;

  typedef enum logic [2:0] {
    StIdle,
    StAttrRd,
    StCheck,
    StFetch,
    StDrain,
    StNext,
    StDone
  } state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [5:0] id;
  } sprite_attr_t;

endpackage

// File: rtl/sprite_pixel_writer.sv
// One-stage pipeline aligning a ROM request with its returned colour code,
// gating transparent pixels and anything right of the visible area.
module sprite_pixel_writer
  import sprite_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned COL_W    = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic [9:0]       x,
  input  logic [COL_W-1:0] col,
  input  logic [3:0]       color_code,
  output logic             lb_we,
  output logic [9:0]       lb_addr,
  output logic [3:0]       lb_data
);

  logic        v1_q;
  logic [10:0] x1_q;

  // Register the request valid and its 11-bit screen x so overflow past 1023 is visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q <= 1'b0;
      x1_q <= 11'd0;
    end else begin
      v1_q <= req;
      x1_q <= {1'b0, x} + {{(11 - COL_W){1'b0}}, col};
    end
  end

  // Write only opaque pixels that land inside the active line.
  always_comb begin
    lb_we   = v1_q && (color_code != TRANSPARENT) && (x1_q < 11'(H_ACTIVE));
    lb_addr = x1_q[9:0];
    lb_data = v1_q ? color_code : 4'h0;
  end

endmodule

// File: rtl/sprite_line_fetcher.sv
// Walks the sprite attribute table during blanking and streams every visible
// sprite row from the ROM bank into the scanline buffer.
module sprite_line_fetcher
  import sprite_pkg::*;
#(
  parameter int unsigned N_SPRITES = 32,
  parameter int unsigned H_ACTIVE  = 640,
  localparam int unsigned IDX_W    = $clog2(N_SPRITES),
  localparam int unsigned COL_W    = $clog2(SPR_SIZE)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [9:0]       vline,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] attr_idx,
  input  logic [9:0]       attr_x,
  input  logic [9:0]       attr_y,
  input  logic [5:0]       attr_id,
  output logic [5:0]       n_sprite,
  output logic [9:0]       line,
  output logic [5:0]       pixel,
  input  logic [3:0]       color_code,
  output logic             lb_we,
  output logic [9:0]       lb_addr,
  output logic [3:0]       lb_data
);

  state_t             state_q, state_d;
  logic [9:0]         vline_q, vline_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [5:0]         id_q, id_d;
  logic [9:0]         x_q, x_d;
  logic [9:0]         row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  sprite_attr_t       attr;
  logic [9:0]         row_calc;

  // State and per-sprite context registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      vline_q <= '0;
      idx_q   <= '0;
      id_q    <= '0;
      x_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      vline_q <= vline_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      x_q     <= x_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Next-state logic and ROM request outputs.
  always_comb begin
    state_d  = state_q;
    vline_d  = vline_q;
    idx_d    = idx_q;
    id_d     = id_q;
    x_d      = x_q;
    row_d    = row_q;
    col_d    = col_q;
    n_sprite = '0;
    line     = '0;
    pixel    = '0;
    attr     = '{x: attr_x, y: attr_y, id: attr_id};
    // Unsigned wrap turns sprites below the line into huge rows.
    row_calc = vline_q - attr.y;

    case (state_q)
      StIdle: begin
        if (start) begin
          vline_d = vline;
          idx_d   = '0;
          state_d = StAttrRd;
        end
      end
      StAttrRd: state_d = StCheck;
      StCheck: begin
        if ((attr.id != 6'd0) && (row_calc < 10'(SPR_SIZE))) begin
          id_d    = attr.id;
          x_d     = attr.x;
          row_d   = row_calc;
          col_d   = '0;
          state_d = StFetch;
        end else begin
          state_d = StNext;
        end
      end
      StFetch: begin
        n_sprite = id_q;
        line     = row_q;
        pixel    = 6'(col_q);
        col_d    = col_q + 1'b1;
        if (col_q == COL_W'(SPR_SIZE - 1)) state_d = StDrain;
      end
      StDrain: state_d = StNext;
      StNext: begin
        if (idx_q == IDX_W'(N_SPRITES - 1)) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StAttrRd;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decode straight from the state register so reset clears them at once.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    attr_idx = idx_q;
  end

  sprite_pixel_writer #(
    .H_ACTIVE (H_ACTIVE),
    .COL_W    (COL_W)
  ) u_writer (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (state_q == StFetch),
    .x          (x_q),
    .col        (col_q),
    .color_code (color_code),
    .lb_we      (lb_we),
    .lb_addr    (lb_addr),
    .lb_data    (lb_data)
  );

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed bench: attribute RAM, sprite ROM and line buffer models around the fetcher.
module tb_sprite_line_fetcher;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [9:0] vline;
  logic       busy, done;
  logic [4:0] attr_idx;
  logic [9:0] attr_x, attr_y;
  logic [5:0] attr_id;
  logic [5:0] n_sprite;
  logic [9:0] line;
  logic [5:0] pixel;
  logic [3:0] color_code;
  logic       lb_we;
  logic [9:0] lb_addr;
  logic [3:0] lb_data;

  sprite_line_fetcher dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .vline      (vline),
    .busy       (busy),
    .done       (done),
    .attr_idx   (attr_idx),
    .attr_x     (attr_x),
    .attr_y     (attr_y),
    .attr_id    (attr_id),
    .n_sprite   (n_sprite),
    .line       (line),
    .pixel      (pixel),
    .color_code (color_code),
    .lb_we      (lb_we),
    .lb_addr    (lb_addr),
    .lb_data    (lb_data)
  );

  always #10 clk = ~clk;

  // Memory models.
  logic [9:0] ax [32];
  logic [9:0] ay [32];
  logic [5:0] aid [32];
  logic [3:0] rom_row [64][32];

  always @(posedge clk) begin
    attr_x     <= ax[attr_idx];
    attr_y     <= ay[attr_idx];
    attr_id    <= aid[attr_idx];
    color_code <= rom_row[n_sprite][pixel[4:0]];
  end

  // Monitor: line buffer contents and request-side sanity.
  bit         mon_clr = 1'b1;
  int         exp_line;
  int         wr_cnt, wr_lo, wr_hi, bad_addr, fetch_cnt, fetch_err, done_cnt;
  logic [4:0] exp_pix;
  logic [3:0] lbuf [1024];

  always @(posedge clk) begin
    if (mon_clr) begin
      wr_cnt    <= 0;
      wr_lo     <= 1023;
      wr_hi     <= 0;
      bad_addr  <= 0;
      fetch_cnt <= 0;
      fetch_err <= 0;
      done_cnt  <= 0;
      exp_pix   <= 5'd0;
      for (int i = 0; i < 1024; i++) lbuf[i] <= 4'hF;
    end else begin
      if (lb_we) begin
        wr_cnt <= wr_cnt + 1;
        if (int'(lb_addr) < wr_lo) wr_lo <= int'(lb_addr);
        if (int'(lb_addr) > wr_hi) wr_hi <= int'(lb_addr);
        if (lb_addr >= 10'd640) bad_addr <= bad_addr + 1;
        lbuf[lb_addr] <= lb_data;
      end
      if (n_sprite != 6'd0) begin
        fetch_cnt <= fetch_cnt + 1;
        if (int'(line) != exp_line || pixel != {1'b0, exp_pix}) fetch_err <= fetch_err + 1;
        exp_pix <= exp_pix + 5'd1;
      end else if (line != 10'd0 || pixel != 6'd0) begin
        fetch_err <= fetch_err + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 32; i++) begin
      ax[i] = 10'd0; ay[i] = 10'd0; aid[i] = 6'd0;
    end
    for (int s = 0; s < 64; s++)
      for (int p = 0; p < 32; p++) rom_row[s][p] = 4'hA;
  endtask

  task automatic mon_reset();
    @(negedge clk); mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  // Start one fill; lat counts cycles from the start cycle to the done cycle (-1 on timeout).
  task automatic run_fill(input int vl, output int lat);
    mon_reset();
    @(negedge clk);
    vline = 10'(vl);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vline = 10'd0;  // later changes must not matter
    lat = 1;
    while (!done && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  typedef struct {
    int x, y, id, vl, color;
    int writes, lo, hi, ln, fetches, lat;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int lat, bad, w;

    tbl[0] = '{x: 100, y: 50,  id: 1, vl: 60, color: 2, writes: 32, lo: 100, hi: 131,
               ln: 10, fetches: 32, lat: 130};
    tbl[1] = '{x: 100, y: 50,  id: 1, vl: 49, color: 2, writes: 0,  lo: 0,   hi: 0,
               ln: 0,  fetches: 0,  lat: 97};
    tbl[2] = '{x: 100, y: 50,  id: 1, vl: 50, color: 3, writes: 32, lo: 100, hi: 131,
               ln: 0,  fetches: 32, lat: 130};
    tbl[3] = '{x: 100, y: 50,  id: 1, vl: 81, color: 4, writes: 32, lo: 100, hi: 131,
               ln: 31, fetches: 32, lat: 130};
    tbl[4] = '{x: 100, y: 50,  id: 1, vl: 82, color: 2, writes: 0,  lo: 0,   hi: 0,
               ln: 0,  fetches: 0,  lat: 97};
    tbl[5] = '{x: 100, y: 60,  id: 1, vl: 5,  color: 2, writes: 0,  lo: 0,   hi: 0,
               ln: 0,  fetches: 0,  lat: 97};
    tbl[6] = '{x: 620, y: 50,  id: 1, vl: 60, color: 7, writes: 20, lo: 620, hi: 639,
               ln: 10, fetches: 32, lat: 130};
    tbl[7] = '{x: 100, y: 50,  id: 0, vl: 60, color: 2, writes: 0,  lo: 0,   hi: 0,
               ln: 0,  fetches: 0,  lat: 97};

    clear_tables();
    exp_line = 0;
    reset_n = 1'b0;
    start = 1'b0;
    vline = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_lb_we", int'(lb_we), 0);
    chk("reset_n_sprite", int'(n_sprite), 0);
    chk("reset_attr_idx", int'(attr_idx), 0);
    @(negedge clk) reset_n = 1'b1;

    // Single-slot table vectors.
    for (int v = 0; v < 8; v++) begin
      clear_tables();
      ax[0] = 10'(tbl[v].x);
      ay[0] = 10'(tbl[v].y);
      aid[0] = 6'(tbl[v].id);
      for (int p = 0; p < 32; p++) rom_row[tbl[v].id][p] = 4'(tbl[v].color);
      exp_line = tbl[v].ln;
      run_fill(tbl[v].vl, lat);
      chk($sformatf("v%0d_latency", v), lat, tbl[v].lat);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", v), int'(done), 0);
      chk($sformatf("v%0d_busy_after", v), int'(busy), 0);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("v%0d_writes", v), wr_cnt, tbl[v].writes);
      chk($sformatf("v%0d_fetches", v), fetch_cnt, tbl[v].fetches);
      chk($sformatf("v%0d_req_err", v), fetch_err, 0);
      chk($sformatf("v%0d_addr_oob", v), bad_addr, 0);
      chk($sformatf("v%0d_done_cnt", v), done_cnt, 1);
      if (tbl[v].writes > 0) begin
        chk($sformatf("v%0d_lo", v), wr_lo, tbl[v].lo);
        chk($sformatf("v%0d_hi", v), wr_hi, tbl[v].hi);
        bad = 0;
        for (int a = tbl[v].lo; a <= tbl[v].hi; a++)
          if (int'(lbuf[a]) != tbl[v].color) bad++;
        chk($sformatf("v%0d_data", v), bad, 0);
      end
    end

    // Transparency and priority: slot 7 over slot 3.
    clear_tables();
    ax[3] = 10'd200; ay[3] = 10'd50; aid[3] = 6'd3;
    ax[7] = 10'd200; ay[7] = 10'd50; aid[7] = 6'd7;
    for (int p = 0; p < 32; p++) begin
      rom_row[3][p] = 4'h5;
      rom_row[7][p] = (p % 2 == 0) ? 4'h6 : 4'h0;
    end
    exp_line = 10;
    run_fill(60, lat);
    chk("prio_latency", lat, 163);
    repeat (3) @(posedge clk);
    #1;
    chk("prio_writes", wr_cnt, 48);
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (lbuf[200 + i] != ((i % 2 == 0) ? 4'h6 : 4'h5)) bad++;
    chk("prio_data", bad, 0);
    chk("prio_req_err", fetch_err, 0);

    // Reset in the middle of a fetch.
    clear_tables();
    ax[0] = 10'd100; ay[0] = 10'd50; aid[0] = 6'd1;
    for (int p = 0; p < 32; p++) rom_row[1][p] = 4'h2;
    exp_line = 10;
    mon_reset();
    @(negedge clk); vline = 10'd60; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    w = 0;
    while (fetch_cnt < 6 && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    chk("mid_fetch_reached", int'(fetch_cnt >= 6), 1);
    chk("pre_reset_we", int'(lb_we), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_lb_we", int'(lb_we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_n_sprite", int'(n_sprite), 0);
    w = wr_cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_writes", wr_cnt, w);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", int'(busy), 0);
    run_fill(60, lat);
    chk("post_rst_latency", lat, 130);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_writes", wr_cnt, 32);
    chk("post_rst_req_err", fetch_err, 0);

    // A second start while busy is ignored.
    mon_reset();
    @(negedge clk); vline = 10'd60; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("dbl_start_done_cnt", done_cnt, 1);
    chk("dbl_start_writes", wr_cnt, 32);
    chk("dbl_start_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
